// File: rtl/gpu_pkg.sv
// Shared types and word counts for the triangle fetch path.
package gpu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } fetch_state_t;

    localparam int VERTEX_WORDS   = 9;
    localparam int TRIANGLE_WORDS = 10;

endpackage

// File: rtl/triangle_fetch.sv
// Fetches one triangle (9 coordinate words + 1 color word) over a 16-bit read master.
// Optional read timeout with fetch_err output: define TRIANGLE_FETCH_TIMEOUT_EN.
module triangle_fetch
    import gpu_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int COORD_WIDTH    = 16,
    parameter int COLOR_WIDTH    = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fetch_start,
    input  logic [ADDR_WIDTH-1:0]  curr_addr_vertex,
    input  logic [ADDR_WIDTH-1:0]  curr_addr_color,
    output logic [COORD_WIDTH-1:0] fetch_vertexes [3][3],
    output logic [COLOR_WIDTH-1:0] fetch_color,
    output logic                   fetch_eoc,
`ifdef TRIANGLE_FETCH_TIMEOUT_EN
    output logic                   fetch_err,
`endif
    output logic [ADDR_WIDTH-1:0]  avm_address,
    output logic                   avm_read,
    input  logic                   avm_waitrequest,
    input  logic [15:0]            avm_readdata,
    input  logic                   avm_readdatavalid
);

    if (COORD_WIDTH != 16 || COLOR_WIDTH != 16 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("triangle_fetch: COORD_WIDTH/COLOR_WIDTH must be 16, TIMEOUT_CYCLES >= 1");
    end

    fetch_state_t           state, state_next;
    logic [3:0]             word_cnt;
    logic [COORD_WIDTH-1:0] shadow [VERTEX_WORDS];
    logic [ADDR_WIDTH-1:0]  color_base;
    logic                   accept, got, last, finish, timeout;
    logic [15:0]            word_in;

    assign accept   = (state == IDLE) && fetch_start;
    assign got      = (state == WAIT) && avm_readdatavalid;
    assign last     = (word_cnt == 4'(TRIANGLE_WORDS - 1));
    assign finish   = (got && last) || timeout;
    // A timed-out word is recorded as zero.
    assign word_in  = timeout ? 16'h0000 : avm_readdata;
    assign avm_read = (state == REQ);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (fetch_start) state_next = REQ;
            REQ:     if (!avm_waitrequest) state_next = WAIT;
            WAIT: begin
                if (finish)   state_next = IDLE;
                else if (got) state_next = REQ;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_cnt    <= '0;
            avm_address <= '0;
            color_base  <= '0;
            fetch_color <= '0;
            fetch_eoc   <= 1'b1;
            for (int k = 0; k < VERTEX_WORDS; k++) shadow[k] <= '0;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++) fetch_vertexes[i][j] <= '0;
        end else if (accept) begin
            // Clearing the shadow leaves never-fetched words at zero after a timeout.
            word_cnt    <= '0;
            avm_address <= curr_addr_vertex;
            color_base  <= curr_addr_color;
            fetch_eoc   <= 1'b0;
            for (int k = 0; k < VERTEX_WORDS; k++) shadow[k] <= '0;
        end else if (finish) begin
            // The final word bypasses the shadow so all ten words land on one edge.
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    fetch_vertexes[i][j] <= (word_cnt == 4'(3*i + j)) ? word_in : shadow[3*i + j];
            fetch_color <= last ? word_in : '0;
            fetch_eoc   <= 1'b1;
            word_cnt    <= '0;
        end else if (got) begin
            shadow[word_cnt] <= avm_readdata;
            word_cnt         <= word_cnt + 4'd1;
            avm_address      <= (word_cnt == 4'(VERTEX_WORDS - 1)) ? color_base
                                                                   : avm_address + ADDR_WIDTH'(2);
        end
    end

`ifdef TRIANGLE_FETCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;

    assign timeout = (state == WAIT) && !avm_readdatavalid && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset || state != WAIT || state_next != WAIT) tmo_cnt <= '0;
        else                                              tmo_cnt <= tmo_cnt + TW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset)        fetch_err <= 1'b0;
        else if (accept)  fetch_err <= 1'b0;
        else if (timeout) fetch_err <= 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_triangle_fetch.sv
// Directed bench for triangle_fetch with a zero/stalling single-outstanding memory model.
module tb_triangle_fetch;

`ifdef TRIANGLE_FETCH_TIMEOUT_EN
    localparam int TB_TMO = 8;
`else
    localparam int TB_TMO = 1024;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_start = 1'b0;
    logic [31:0] curr_addr_vertex = '0;
    logic [31:0] curr_addr_color = '0;
    logic [15:0] fetch_vertexes [3][3];
    logic [15:0] fetch_color;
    logic        fetch_eoc;
    logic        fetch_err_w;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_waitrequest = 1'b0;
    logic [15:0] avm_readdata = '0;
    logic        avm_readdatavalid = 1'b0;

    triangle_fetch #(.ADDR_WIDTH(32), .COORD_WIDTH(16), .COLOR_WIDTH(16), .TIMEOUT_CYCLES(TB_TMO)) dut (
        .clk(clk),
        .reset(reset),
        .fetch_start(fetch_start),
        .curr_addr_vertex(curr_addr_vertex),
        .curr_addr_color(curr_addr_color),
        .fetch_vertexes(fetch_vertexes),
        .fetch_color(fetch_color),
        .fetch_eoc(fetch_eoc),
`ifdef TRIANGLE_FETCH_TIMEOUT_EN
        .fetch_err(fetch_err_w),
`endif
        .avm_address(avm_address),
        .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid)
    );

`ifndef TRIANGLE_FETCH_TIMEOUT_EN
    assign fetch_err_w = 1'b0;
`endif

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          cyc0 = 0;
    int          read_idx = 0;
    int          stall_word = -1;
    int          stall_left = 0;
    int          drop_word = -1;
    logic        pend = 1'b0;
    logic [15:0] pend_data = '0;
    logic [31:0] addr_log [$];
    int          cyc_log [$];

    // One cycle: memory model acts on the falling edge, checks happen 1 ns later.
    // Memory word at address a holds a[15:0] + 0x0100.
    task automatic tick();
        @(negedge clk);
        cyc++;
        avm_readdatavalid = pend;
        avm_readdata      = pend_data;
        pend              = 1'b0;
        avm_waitrequest   = 1'b0;
        if (avm_read) begin
            if (read_idx == stall_word && stall_left > 0) begin
                avm_waitrequest = 1'b1;
                stall_left--;
            end else begin
                addr_log.push_back(avm_address);
                cyc_log.push_back(cyc);
                pend      = (read_idx != drop_word);
                pend_data = avm_address[15:0] + 16'h0100;
                read_idx++;
            end
        end
        #1;
    endtask

    task automatic run_fetch(input logic [31:0] vb, input logic [31:0] cb, input int sw, input int sn,
                             input int dw, input int rs_cyc, input int rst_cyc, input logic [31:0] hold_addr,
                             output int lat, output int bad_hold, output logic [15:0] col1, output logic err1);
        read_idx   = 0;
        stall_word = sw;
        stall_left = sn;
        drop_word  = dw;
        addr_log.delete();
        cyc_log.delete();
        lat      = -1;
        bad_hold = 0;
        col1     = '0;
        err1     = 1'b0;
        tick();
        cyc0             = cyc;
        curr_addr_vertex = vb;
        curr_addr_color  = cb;
        fetch_start      = 1'b1;
        for (int n = 1; n <= 200 && lat < 0; n++) begin
            tick();
            if (n == 1) begin
                col1 = fetch_color;
                err1 = fetch_err_w;
            end
            if (avm_waitrequest && (!avm_read || avm_address !== hold_addr)) bad_hold++;
            if (fetch_eoc) lat = n;
            fetch_start = (n == rs_cyc);
            reset       = (n == rst_cyc);
        end
        fetch_start = 1'b0;
        reset       = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_cmp++; if (fetch_eoc !== 1'b1) begin $display("FAIL reset_eoc: got %b want 1", fetch_eoc); n_err++; end
        n_cmp++; if (avm_read !== 1'b0) begin $display("FAIL reset_read: got %b want 0", avm_read); n_err++; end
        n_cmp++; if (avm_address !== 32'h0) begin $display("FAIL reset_addr: got %h want 0", avm_address); n_err++; end
        n_cmp++; if (fetch_color !== 16'h0) begin $display("FAIL reset_color: got %h want 0", fetch_color); n_err++; end
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                n_cmp++;
                if (fetch_vertexes[i][j] !== 16'h0) begin
                    $display("FAIL reset_vtx[%0d][%0d]: got %h want 0", i, j, fetch_vertexes[i][j]); n_err++;
                end
            end
        tick();
        reset = 1'b1;
        fetch_start = 1'b1;
        tick();
        reset = 1'b0;
        fetch_start = 1'b0;
        n_cmp++; if (avm_read !== 1'b0 || fetch_eoc !== 1'b1) begin
            $display("FAIL reset_priority: read=%b eoc=%b want read=0 eoc=1", avm_read, fetch_eoc); n_err++;
        end
        tick();
        n_cmp++; if (avm_read !== 1'b0) begin $display("FAIL reset_priority_late: read=%b want 0", avm_read); n_err++; end
    endtask

    task automatic test_basic();
        int lat, bad; logic [15:0] c1; logic e1;
        logic [31:0] ea;
        run_fetch(32'h1000, 32'h2000, -1, 0, -1, -1, -1, 32'h0, lat, bad, c1, e1);
        n_cmp++; if (lat !== 21) begin $display("FAIL basic_latency: got %0d want 21", lat); n_err++; end
        n_cmp++; if (addr_log.size() !== 10) begin $display("FAIL basic_nreads: got %0d want 10", addr_log.size()); n_err++; end
        for (int k = 0; k < 10 && k < addr_log.size(); k++) begin
            ea = (k < 9) ? 32'h1000 + 32'(2*k) : 32'h2000;
            n_cmp++;
            if (addr_log[k] !== ea) begin $display("FAIL basic_addr%0d: got %h want %h", k, addr_log[k], ea); n_err++; end
            n_cmp++;
            if (cyc_log[k] - cyc0 !== 1 + 2*k) begin
                $display("FAIL basic_issue%0d: got cycle %0d want %0d", k, cyc_log[k] - cyc0, 1 + 2*k); n_err++;
            end
        end
        n_cmp++; if (fetch_vertexes[1][2] !== 16'h110A) begin $display("FAIL basic_v12: got %h want 110a", fetch_vertexes[1][2]); n_err++; end
        n_cmp++; if (fetch_vertexes[0][0] !== 16'h1100) begin $display("FAIL basic_v00: got %h want 1100", fetch_vertexes[0][0]); n_err++; end
        n_cmp++; if (fetch_vertexes[2][2] !== 16'h1110) begin $display("FAIL basic_v22: got %h want 1110", fetch_vertexes[2][2]); n_err++; end
        n_cmp++; if (fetch_color !== 16'h2100) begin $display("FAIL basic_color: got %h want 2100", fetch_color); n_err++; end
    endtask

    task automatic test_waitrequest();
        int lat, bad; logic [15:0] c1; logic e1;
        run_fetch(32'h1000, 32'h2000, 3, 5, -1, -1, -1, 32'h1006, lat, bad, c1, e1);
        n_cmp++; if (c1 !== 16'h2100) begin $display("FAIL hold_prev_color: got %h want 2100", c1); n_err++; end
        n_cmp++; if (bad !== 0) begin $display("FAIL stall_hold: %0d stalled cycles without read@1006", bad); n_err++; end
        n_cmp++; if (lat !== 26) begin $display("FAIL stall_latency: got %0d want 26", lat); n_err++; end
        n_cmp++; if (fetch_vertexes[1][0] !== 16'h1106) begin $display("FAIL stall_v10: got %h want 1106", fetch_vertexes[1][0]); n_err++; end
    endtask

    task automatic test_restart_ignored();
        int lat, bad; logic [15:0] c1; logic e1;
        run_fetch(32'h1000, 32'h3000, -1, 0, -1, 7, -1, 32'h0, lat, bad, c1, e1);
        n_cmp++; if (addr_log.size() !== 10) begin $display("FAIL restart_nreads: got %0d want 10", addr_log.size()); n_err++; end
        n_cmp++; if (lat !== 21) begin $display("FAIL restart_latency: got %0d want 21", lat); n_err++; end
        n_cmp++; if (fetch_color !== 16'h3100) begin $display("FAIL restart_color: got %h want 3100", fetch_color); n_err++; end
        repeat (4) tick();
        n_cmp++; if (avm_read !== 1'b0 || fetch_eoc !== 1'b1) begin
            $display("FAIL restart_idle: read=%b eoc=%b want 0/1", avm_read, fetch_eoc); n_err++;
        end
    endtask

    task automatic test_wrap();
        int lat, bad; logic [15:0] c1; logic e1;
        run_fetch(32'hFFFF_FFFC, 32'h2000, -1, 0, -1, -1, -1, 32'h0, lat, bad, c1, e1);
        n_cmp++; if (c1 !== 16'h3100) begin $display("FAIL wrap_prev_color: got %h want 3100", c1); n_err++; end
        n_cmp++; if (lat !== 21) begin $display("FAIL wrap_latency: got %0d want 21", lat); n_err++; end
        n_cmp++; if (addr_log.size() < 3 || addr_log[2] !== 32'h0) begin
            $display("FAIL wrap_addr2: got %h want 00000000", addr_log.size() >= 3 ? addr_log[2] : 32'hx); n_err++;
        end
        n_cmp++; if (fetch_vertexes[0][0] !== 16'h00FC) begin $display("FAIL wrap_v00: got %h want 00fc", fetch_vertexes[0][0]); n_err++; end
        n_cmp++; if (fetch_vertexes[0][2] !== 16'h0100) begin $display("FAIL wrap_v02: got %h want 0100", fetch_vertexes[0][2]); n_err++; end
    endtask

    task automatic test_reset_mid_fetch();
        int lat, bad; logic [15:0] c1; logic e1;
        run_fetch(32'h1000, 32'h2000, -1, 0, -1, -1, 9, 32'h0, lat, bad, c1, e1);
        n_cmp++; if (lat !== 10) begin $display("FAIL rstmid_eoc_cycle: got %0d want 10", lat); n_err++; end
        n_cmp++; if (avm_read !== 1'b0) begin $display("FAIL rstmid_read: got %b want 0", avm_read); n_err++; end
        n_cmp++; if (fetch_vertexes[0][0] !== 16'h0 || fetch_color !== 16'h0) begin
            $display("FAIL rstmid_outputs: v00=%h color=%h want 0/0", fetch_vertexes[0][0], fetch_color); n_err++;
        end
        repeat (3) tick();
        n_cmp++; if (avm_read !== 1'b0 || fetch_eoc !== 1'b1 || fetch_vertexes[1][1] !== 16'h0) begin
            $display("FAIL rstmid_late_valid: read=%b eoc=%b v11=%h want 0/1/0", avm_read, fetch_eoc, fetch_vertexes[1][1]); n_err++;
        end
    endtask

`ifdef TRIANGLE_FETCH_TIMEOUT_EN
    task automatic test_timeout();
        int lat, bad; logic [15:0] c1; logic e1;
        run_fetch(32'h1000, 32'h2000, -1, 0, 4, -1, -1, 32'h0, lat, bad, c1, e1);
        n_cmp++; if (lat < 0) begin $display("FAIL tmo_no_finish: eoc never rose"); n_err++; end
        n_cmp++; if (fetch_err_w !== 1'b1) begin $display("FAIL tmo_err: got %b want 1", fetch_err_w); n_err++; end
        n_cmp++; if (fetch_vertexes[1][1] !== 16'h0) begin $display("FAIL tmo_v11: got %h want 0", fetch_vertexes[1][1]); n_err++; end
        n_cmp++; if (fetch_vertexes[1][0] !== 16'h1106) begin $display("FAIL tmo_v10: got %h want 1106", fetch_vertexes[1][0]); n_err++; end
        run_fetch(32'h1000, 32'h2000, -1, 0, -1, -1, -1, 32'h0, lat, bad, c1, e1);
        n_cmp++; if (e1 !== 1'b0) begin $display("FAIL tmo_err_clear: got %b want 0", e1); n_err++; end
        n_cmp++; if (lat !== 21) begin $display("FAIL tmo_refetch_latency: got %0d want 21", lat); n_err++; end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_waitrequest();
        test_restart_ignored();
        test_wrap();
        test_reset_mid_fetch();
`ifdef TRIANGLE_FETCH_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
